// File: rtl/job_sequencer_pkg.sv
// Shared definitions for the job sequencer: FSM state encoding and watchdog width.
package job_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam int unsigned WDOG_W = 8;

endpackage

// File: rtl/job_sequencer_op.sv
// Circular operand FIFO; pushes when not full, pops when not empty.
module op_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/job_sequencer.sv
// Dispatches buffered operands to a start/done compute unit, captures results
// for a valid/ready consumer, and abandons jobs whose done never arrives.
module job_sequencer
  import job_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       op_data,
  output logic                   start,
  input  logic                   done,
  input  logic [2*WIDTH-1:0]     result_in,
  output logic [2*WIDTH-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     op_data_q, op_data_d;
  logic                 start_q, start_d;
  logic [2*WIDTH-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WIDTH-1:0]     fifo_head;

  op_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign in_ready    = !fifo_full;
  assign op_data     = op_data_q;
  assign start       = start_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    op_data_d     = op_data_q;
    start_d       = 1'b0;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    timeout_err_d = timeout_err_q;
    wdog_d        = wdog_q;
    fifo_pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          op_data_d = fifo_head;
          start_d   = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        // done takes priority over a coincident watchdog expiry
        if (done) begin
          out_data_d  = result_in;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = done ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      op_data_q     <= '0;
      start_q       <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      op_data_q     <= op_data_d;
      start_q       <= start_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
      wdog_q        <= wdog_d;
    end
  end

endmodule

// File: tb/tb_job_sequencer.sv
// Randomized scoreboard bench for job_sequencer with a behavioural compute-unit responder.
module tb_job_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned TO = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   op_data;
  logic           start;
  logic           done;
  logic [2*W-1:0] result_in;
  logic [2*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic           timeout_err;
  logic [2:0]     count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [W-1:0]   fifo_model[$];
  logic [2*W-1:0] exp_q[$];
  logic           exp_timeout = 1'b0;
  logic           resp_en = 1'b0;
  logic           prev_start = 1'b0;

  job_sequencer #(
    .WIDTH   (W),
    .DEPTH   (D),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_data     (op_data),
    .start       (start),
    .done        (done),
    .result_in   (result_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},    32'(in_ready),    1);
    chk({tag, "_start"},       32'(start),       0);
    chk({tag, "_busy"},        32'(busy),        0);
    chk({tag, "_op_data"},     32'(op_data),     0);
    chk({tag, "_out_data"},    32'(out_data),    0);
    chk({tag, "_out_valid"},   32'(out_valid),   0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_count"},       32'(count),       0);
  endtask

  // Monitor: FIFO occupancy model, dispatch order, result scoreboard, error flag.
  always @(negedge clk) begin
    if (rst) begin
      if (start) begin
        chk("start_has_word", 32'(fifo_model.size() != 0), 1);
        if (fifo_model.size() != 0) chk("op_data_order", 32'(op_data), 32'(fifo_model.pop_front()));
        chk("start_while_done", 32'(done), 0);
        chk("start_one_cycle", 32'(prev_start), 0);
      end
      prev_start = start;
      chk("count", 32'(count), 32'(fifo_model.size()));
      chk("in_ready", 32'(in_ready), 32'(fifo_model.size() < D));
      chk("timeout_err", 32'(timeout_err), 32'(exp_timeout));
      if (out_valid) begin
        chk("out_valid_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("out_data", 32'(out_data), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) fifo_model.push_back(in_data);
    end else begin
      prev_start = 1'b0;
    end
  end

  // Compute-unit responder: done on WAIT cycle k, or never if k exceeds the watchdog limit.
  initial begin
    int unsigned k;
    logic [2*W-1:0] res;
    forever begin
      @(negedge clk);
      if (rst && resp_en && start) begin
        k = $urandom_range(1, TO + 3);
        @(posedge clk);
        if (k > TO) begin
          repeat (TO) @(posedge clk);
          #1 exp_timeout = 1'b1;
        end else begin
          repeat (k - 1) @(posedge clk);
          #1;
          res = 16'($urandom);
          result_in = res;
          done = 1'b1;
          exp_q.push_back(res);
          if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1 done = 1'b0;
          end else begin
            for (int n = 0; n < 1000; n++) begin
              @(negedge clk);
              if (out_valid && out_ready) break;
            end
            @(posedge clk);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1 done = 1'b0;
            result_in = 16'($urandom);
          end
        end
      end
    end
  end

  task automatic drain(input string tag);
    int unsigned n = 0;
    while (!(fifo_model.size() == 0 && exp_q.size() == 0 && !busy && !done) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_bound"}, 32'(n < 3000), 1);
  endtask

  initial begin
    logic seen;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    done = 1'b0; result_in = '0;
    repeat (2) @(posedge clk);
    #2 check_reset_vals("por");
    @(posedge clk);
    #2 rst = 1'b1;
    resp_en = 1'b1;

    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 40) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    drain("random");

    // Asynchronous reset in the middle of a WAIT
    resp_en = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = start;
    end
    chk("rst_job_started", 32'(seen), 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    exp_timeout = 1'b0;
    fifo_model.delete();
    exp_q.delete();
    check_reset_vals("midrst");
    @(posedge clk);
    #2 rst = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      seen = seen | start | busy;
    end
    chk("idle_after_reset", 32'(seen), 0);

    resp_en = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b1; in_data = 8'h3C;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/job_sequencer.md
# job_sequencer

Front-end dispatcher that sits directly upstream of the multi-cycle compute unit and its start/done controller. It buffers operand words from a producer in a small FIFO and issues them to the compute unit one at a time. For each job it pulses `start`, waits for `done`, captures the result, and offers it to a consumer over a valid/ready handshake. A watchdog drops any job whose `done` never arrives.

## Interface
- `WIDTH`, 8, operand width; results are 2*WIDTH.
- `DEPTH`, 4, operand FIFO depth; power of two, ≥2.
- `TIMEOUT`, 255, maximum WAIT cycles before a job is abandoned; 1..255, watchdog is 8 bits.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-low. All registers clear immediately when `rst`=0.
- `in_data`  in  WIDTH  operand from producer.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  = !full; a word is pushed on an edge where `in_valid`&&`in_ready`.
- `op_data`  out  WIDTH  registered operand presented to the compute datapath.
- `start`  out  1  registered one-cycle pulse to the controller.
- `done`  in  1  controller done level.
- `result_in`  in  2*WIDTH  datapath result; valid while `done`=1.
- `out_data`  out  2*WIDTH  captured result.
- `out_valid`  out  1  result offered to consumer.
- `out_ready`  in  1  consumer accepts.
- `busy`  out  1  FSM not in IDLE.
- `timeout_err`  out  1  sticky; set when a job is dropped.
- `count`  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
FSM states: IDLE, START, WAIT, HOLD, DRAIN.

- **IDLE**
  - If `count`>0: pop the head into `op_data`, go to START.
  - Otherwise stay in IDLE.
- **START**
  - `start`=1 for exactly this state.
  - Clear the watchdog.
  - Next state is always WAIT.
- **WAIT**
  - Watchdog increments each cycle.
  - If `done`=1: latch `result_in` into `out_data`, set `out_valid`, go to HOLD.
  - Else if the watchdog equals TIMEOUT-1: set `timeout_err`, go to IDLE. The job is discarded and `out_valid` stays 0.
  - If `done` arrives on the same cycle as the timeout, `done` wins.
- **HOLD**
  - `out_valid`=1 and `out_data` stay stable until `out_valid`&&`out_ready`.
  - On handshake: clear `out_valid`. Go to IDLE if `done`=0, else go to DRAIN.
- **DRAIN**
  - Wait until `done`=0, then go to IDLE.
  - This guarantees no `start` is issued while the controller is still showing the previous `done`.

Other rules:
- `op_data` holds its value from START until the next pop.
- FIFO behaviour:
  - Circular, with log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH.
  - Push and pop on the same edge leave `count` unchanged.
  - No push while full: `in_ready`=0, so a simultaneous pop does not admit a word in that cycle.
  - Pops happen only on the IDLE→START edge; an empty FIFO is never popped.
- `timeout_err` clears only on reset.
- Reset mid-job: the FSM returns to IDLE, the FIFO is emptied, and any in-flight result is lost.

## Timing
- Reset values:
  - `in_ready`=1
  - `start`=0, `busy`=0
  - `op_data`=0, `out_data`=0
  - `out_valid`=0, `timeout_err`=0, `count`=0
- Dispatch latency, for an idle block receiving a word at edge E0:
  - E1: IDLE→START and pop. `start` and `op_data` are valid from E1 to E2.
  - E2: START→WAIT.
- Capture: `done` high before edge Ek gives `out_valid`=1 after Ek.
- Back-to-back throughput:
  - Minimum 4 cycles per job plus the compute time.
  - The next `start` comes at the earliest one cycle after the result handshake and `done` low.

## Structure
- Shared package holds:
  - FSM state encoding constants (3-bit; IDLE=0, START=1, WAIT=2, HOLD=3, DRAIN=4).
  - The watchdog width constant.
- One sub-module, `op_fifo`: parameterised by WIDTH and DEPTH, with push, pop, data, full, empty and count.
- FSM, watchdog and output registers live in `job_sequencer`.

## Test plan
- **Single job.** After reset push 8'h5A; `done` rises 6 cycles after `start` with `result_in`=16'h1234.
  - `start` is high for exactly 1 cycle.
  - `op_data`=8'h5A.
  - `out_data`=16'h1234 with `out_valid`=1 after that edge.
  - Returns to IDLE after `out_ready` and `done` low.
- **Fill and wrap.** Push 6 words with DEPTH=4 while the compute unit is stalled.
  - `in_ready` drops at `count`=4.
  - Words are dispatched in order, including after pointer wrap.
  - Push and pop on the same edge leave `count` constant.
- **Timeout.** TIMEOUT=10; never raise `done`.
  - `timeout_err`=1 after the 10th WAIT cycle.
  - `out_valid` stays 0.
  - The next queued word gets `start` afterwards.
  - `done` asserted on the 10th WAIT cycle instead is captured, with no error.
- **Backpressure and DRAIN.**
  - Hold `out_ready`=0 for 5 cycles: `out_data` stays stable.
  - Keep `done`=1 after the handshake: the FSM stays in DRAIN with no `start` until `done`=0.
- **Async reset mid-WAIT.** Drive `rst`=0 between clock edges.
  - All outputs reach their reset values immediately.
  - `count`=0.
  - No `start` follows release until a new push.
